// File: rtl/pueo_l2_trigctrl.sv
// pueo_l2_trigctrl
// Sequencing controller for the L2 trigger stage. Accepts L2 master
// triggers while live, applies a programmable holdoff and buffer-credit
// deadtime, numbers accepted events and hands them to the event builder
// over valid/ready, tracks buffer occupancy until readout releases each
// buffer, and accumulates dead-time / rejected-trigger statistics.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   ce_i                  sysclk_x2 enable; triggers and holdoff ticks qualified on it
//   run_i, clr_i          run enable level, statistics clear pulse (IDLE, occupancy 0 only)
//   holdoff_len_i         holdoff length in ce_i ticks, sampled at accept
//   trig_i                L2 master trigger pulse
//   holdoff_o, dead_o     registered feedback to the L2 stage
//   evt_valid_o/ready_i   event-number handshake, evt_num_o = oldest un-emitted event
//   buf_release_i         readout freed one buffer
//   occupancy_o           buffers accepted but not yet released
//   dead_cnt_o, rej_cnt_o saturating statistics counters
//   err_o                 sticky error (illegal release or rejected trigger)
module pueo_l2_trigctrl #(
    parameter int NBUF       = 4,
    parameter int HOLD_BITS  = 16,
    parameter int EVNUM_BITS = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ce_i,
    input  logic                  run_i,
    input  logic                  clr_i,
    input  logic [HOLD_BITS-1:0]  holdoff_len_i,
    input  logic                  trig_i,
    output logic                  holdoff_o,
    output logic                  dead_o,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [EVNUM_BITS-1:0] evt_num_o,
    input  logic                  buf_release_i,
    output logic [3:0]            occupancy_o,
    output logic [31:0]           dead_cnt_o,
    output logic [15:0]           rej_cnt_o,
    output logic                  err_o
);

    localparam logic [3:0] NBUF_L = 4'(NBUF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [HOLD_BITS-1:0]    hold_cnt_r, hold_cnt_nx_s;
    logic [EVNUM_BITS-1:0]   acc_num_r, emit_num_r, pending_s;
    logic [3:0]              occ_r, occ_nx_s;
    logic                    holdoff_r, dead_r, err_r;
    logic [31:0]             dead_cnt_r;
    logic [15:0]             rej_cnt_r;
    logic                    accept_s, reject_s, hs_s, rel_ok_s, rel_bad_s;
    logic                    clear_s, dead_tick_s, valid_s;

    // pending is bounded by NBUF, so its low nibble is the full value
    assign pending_s   = acc_num_r - emit_num_r;
    assign valid_s     = (pending_s != {EVNUM_BITS{1'b0}});
    assign hs_s        = valid_s & evt_ready_i;
    assign accept_s    = ce_i & trig_i & run_i & (state_r == ARMED) & (occ_r < NBUF_L);
    assign reject_s    = ce_i & trig_i & ~accept_s;
    // only buffers whose event number has already been emitted may be released
    assign rel_ok_s    = buf_release_i & (occ_r > pending_s[3:0]);
    assign rel_bad_s   = buf_release_i & ~rel_ok_s;
    assign clear_s     = clr_i & (state_r == IDLE) & (occ_r == 4'd0);
    assign dead_tick_s = ce_i & run_i & (dead_r | holdoff_r);

    // next state and holdoff counter
    always_comb begin
        state_nx_s    = state_r;
        hold_cnt_nx_s = hold_cnt_r;
        if (!run_i) begin
            state_nx_s    = IDLE;
            hold_cnt_nx_s = {HOLD_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = ARMED;
                end
                ARMED: begin
                    if (accept_s && (holdoff_len_i != {HOLD_BITS{1'b0}})) begin
                        state_nx_s    = HOLD;
                        hold_cnt_nx_s = holdoff_len_i;
                    end else begin
                        state_nx_s = ARMED;
                    end
                end
                HOLD: begin
                    if (ce_i) begin
                        hold_cnt_nx_s = hold_cnt_r - HOLD_BITS'(1);
                        if (hold_cnt_r == HOLD_BITS'(1)) begin
                            state_nx_s = ARMED;
                        end else begin
                            state_nx_s = HOLD;
                        end
                    end else begin
                        state_nx_s = HOLD;
                    end
                end
                default: begin
                    state_nx_s    = IDLE;
                    hold_cnt_nx_s = {HOLD_BITS{1'b0}};
                end
            endcase
        end
    end

    // occupancy: accept adds a buffer, legal release frees one, both cancel
    always_comb begin
        occ_nx_s = occ_r;
        case ({accept_s, rel_ok_s})
            2'b10:   occ_nx_s = occ_r + 4'd1;
            2'b01:   occ_nx_s = occ_r - 4'd1;
            default: occ_nx_s = occ_r;
        endcase
    end

    // state, occupancy and registered L2 feedback (dead uses next-state values)
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HOLD_BITS{1'b0}};
            occ_r      <= 4'd0;
            holdoff_r  <= 1'b0;
            dead_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            hold_cnt_r <= hold_cnt_nx_s;
            occ_r      <= occ_nx_s;
            holdoff_r  <= (state_nx_s == HOLD);
            dead_r     <= (state_nx_s == IDLE) | (occ_nx_s == NBUF_L);
        end
    end

    // event numbering, statistics and sticky error; clear has priority
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_num_r  <= {EVNUM_BITS{1'b0}};
            emit_num_r <= {EVNUM_BITS{1'b0}};
            dead_cnt_r <= 32'd0;
            rej_cnt_r  <= 16'd0;
            err_r      <= 1'b0;
        end else if (clear_s) begin
            acc_num_r  <= {EVNUM_BITS{1'b0}};
            emit_num_r <= {EVNUM_BITS{1'b0}};
            dead_cnt_r <= 32'd0;
            rej_cnt_r  <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            if (accept_s) acc_num_r <= acc_num_r + EVNUM_BITS'(1);
            if (hs_s) emit_num_r <= emit_num_r + EVNUM_BITS'(1);
            if (dead_tick_s && (dead_cnt_r != 32'hFFFF_FFFF)) dead_cnt_r <= dead_cnt_r + 32'd1;
            if (reject_s && (rej_cnt_r != 16'hFFFF)) rej_cnt_r <= rej_cnt_r + 16'd1;
            if (reject_s || rel_bad_s) err_r <= 1'b1;
        end
    end

    assign holdoff_o   = holdoff_r;
    assign dead_o      = dead_r;
    assign evt_valid_o = valid_s;
    assign evt_num_o   = emit_num_r;
    assign occupancy_o = occ_r;
    assign dead_cnt_o  = dead_cnt_r;
    assign rej_cnt_o   = rej_cnt_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_pueo_l2_trigctrl.sv
// Directed bench for pueo_l2_trigctrl: a vector table with hand-computed
// expected outputs, followed by hand-written multi-cycle sequences for
// ce_i gating, run drop mid-holdoff, clear gating and async reset.
module tb_pueo_l2_trigctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1, run = 1'b0, clr = 1'b0, trig = 1'b0, rdy = 1'b0, rel = 1'b0;
    logic [15:0] hl = 16'd0;
    logic        holdoff, dead, valid, err;
    logic [31:0] num, dcnt;
    logic [3:0]  occ;
    logic [15:0] rej;

    int nchk = 0;
    int nerr = 0;

    pueo_l2_trigctrl #(.NBUF(4), .HOLD_BITS(16), .EVNUM_BITS(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .run_i(run), .clr_i(clr),
        .holdoff_len_i(hl), .trig_i(trig), .holdoff_o(holdoff), .dead_o(dead),
        .evt_valid_o(valid), .evt_ready_i(rdy), .evt_num_o(num),
        .buf_release_i(rel), .occupancy_o(occ), .dead_cnt_o(dcnt),
        .rej_cnt_o(rej), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, trig;
        logic [15:0] hl;
        logic        rdy, rel, clr;
        logic        eh, ed, ev;
        logic [31:0] en;
        logic [3:0]  eo;
        logic [15:0] er;
        logic        ee;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[40];

    function automatic vec_t mk(input logic r, t, input logic [15:0] h, input logic y, l, c,
                                input logic eh, ed, ev, input logic [31:0] en,
                                input logic [3:0] eo, input logic [15:0] er,
                                input logic ee, input logic [31:0] ec);
        vec_t v;
        v.run = r; v.trig = t; v.hl = h; v.rdy = y; v.rel = l; v.clr = c;
        v.eh = eh; v.ed = ed; v.ev = ev; v.en = en; v.eo = eo; v.er = er; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, t, input logic [15:0] h, input logic y, l, c);
        @(negedge clk);
        run = r; trig = t; hl = h; rdy = y; rel = l; clr = c;
    endtask

    initial begin
        int ticks;
        //            run trg hl rdy rel clr | hold dead val num occ rej err dcnt
        tbl[0]  = mk(1, 0, 16'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 16'd5, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 1);
        tbl[2]  = mk(1, 0, 16'd9, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 2);
        tbl[3]  = mk(1, 0, 16'd9, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 3);
        tbl[4]  = mk(1, 0, 16'd9, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 4);
        tbl[5]  = mk(1, 0, 16'd9, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 5);
        tbl[6]  = mk(1, 0, 16'd0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 6);
        tbl[7]  = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 6);
        tbl[8]  = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 6);
        tbl[9]  = mk(1, 1, 16'd0, 1, 0, 0,  0, 0, 1, 1, 1, 0, 0, 6);
        tbl[10] = mk(1, 1, 16'd0, 1, 0, 0,  0, 0, 1, 2, 2, 0, 0, 6);
        tbl[11] = mk(1, 1, 16'd0, 1, 0, 0,  0, 0, 1, 3, 3, 0, 0, 6);
        tbl[12] = mk(1, 1, 16'd0, 1, 0, 0,  0, 1, 1, 4, 4, 0, 0, 6);
        tbl[13] = mk(1, 1, 16'd0, 1, 0, 0,  0, 1, 0, 5, 4, 1, 1, 7);
        tbl[14] = mk(1, 0, 16'd0, 1, 1, 0,  0, 0, 0, 5, 3, 1, 1, 8);
        tbl[15] = mk(1, 1, 16'd0, 0, 1, 0,  0, 0, 1, 5, 3, 1, 1, 8);
        tbl[16] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 0, 6, 3, 1, 1, 8);
        tbl[17] = mk(1, 1, 16'd0, 1, 0, 0,  0, 1, 1, 6, 4, 1, 1, 8);
        tbl[18] = mk(1, 1, 16'd0, 0, 1, 0,  0, 0, 1, 6, 3, 2, 1, 9);
        tbl[19] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 0, 7, 3, 2, 1, 9);
        tbl[20] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 7, 2, 2, 1, 9);
        tbl[21] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 7, 1, 2, 1, 9);
        tbl[22] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 7, 0, 2, 1, 9);
        tbl[23] = mk(0, 0, 16'd0, 0, 0, 0,  0, 1, 0, 7, 0, 2, 1, 9);
        tbl[24] = mk(0, 0, 16'd0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 0, 16'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        tbl[26] = mk(1, 1, 16'd0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 1);
        tbl[27] = mk(1, 1, 16'd0, 0, 0, 0,  0, 0, 1, 0, 2, 0, 0, 1);
        tbl[28] = mk(1, 1, 16'd0, 0, 0, 0,  0, 0, 1, 0, 3, 0, 0, 1);
        tbl[29] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 1, 1, 3, 0, 0, 1);
        tbl[30] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 1, 2, 3, 0, 0, 1);
        tbl[31] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 0, 3, 3, 0, 0, 1);
        tbl[32] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 3, 2, 0, 0, 1);
        tbl[33] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 3, 1, 0, 0, 1);
        tbl[34] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 0, 3, 0, 0, 0, 1);
        tbl[35] = mk(1, 1, 16'd0, 0, 0, 0,  0, 0, 1, 3, 1, 0, 0, 1);
        tbl[36] = mk(1, 1, 16'd0, 0, 0, 0,  0, 0, 1, 3, 2, 0, 0, 1);
        tbl[37] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 1, 3, 2, 0, 1, 1);
        tbl[38] = mk(1, 0, 16'd0, 1, 0, 0,  0, 0, 1, 4, 2, 0, 1, 1);
        tbl[39] = mk(1, 0, 16'd0, 0, 1, 0,  0, 0, 1, 4, 1, 0, 1, 1);

        // reset state
        #12;
        chk("rst_dead", {31'd0, dead}, 32'd1);
        chk("rst_hold", {31'd0, holdoff}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_occ", {28'd0, occ}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            drive(tbl[i].run, tbl[i].trig, tbl[i].hl, tbl[i].rdy, tbl[i].rel, tbl[i].clr);
            tick();
            chk($sformatf("v%0d_hold", i), {31'd0, holdoff}, {31'd0, tbl[i].eh});
            chk($sformatf("v%0d_dead", i), {31'd0, dead}, {31'd0, tbl[i].ed});
            chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_num", i), num, tbl[i].en);
            chk($sformatf("v%0d_occ", i), {28'd0, occ}, {28'd0, tbl[i].eo});
            chk($sformatf("v%0d_rej", i), {16'd0, rej}, {16'd0, tbl[i].er});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].ee});
            chk($sformatf("v%0d_dcnt", i), dcnt, tbl[i].ec);
        end

        // holdoff counts ce_i ticks, not clocks: length 3 with ce every other cycle
        drive(1, 1, 16'd3, 0, 0, 0);
        tick();
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            trig = 1'b0; hl = 16'd0; ce = (i % 2 == 1);
            #1;
            if (ce && holdoff) ticks++;
            tick();
        end
        chk("ce_hold_ticks", ticks, 32'd3);
        chk("ce_dcnt", dcnt, 32'd4);
        chk("ce_hold_end", {31'd0, holdoff}, 32'd0);
        // trigger without ce_i is not seen at all
        @(negedge clk);
        ce = 1'b0; trig = 1'b1;
        tick();
        chk("noce_occ", {28'd0, occ}, 32'd2);
        chk("noce_rej", {16'd0, rej}, 32'd0);
        @(negedge clk);
        ce = 1'b1; trig = 1'b0;

        // run dropped mid-holdoff
        drive(1, 1, 16'd10, 0, 0, 0);
        tick();
        chk("rd_hold_on", {31'd0, holdoff}, 32'd1);
        drive(1, 0, 16'd0, 0, 0, 0);
        tick();
        drive(0, 0, 16'd0, 0, 0, 0);
        tick();
        chk("rd_hold_off", {31'd0, holdoff}, 32'd0);
        chk("rd_dead", {31'd0, dead}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("rd_dcnt_stop", dcnt, 32'd5);
        chk("rd_occ_kept", {28'd0, occ}, 32'd3);

        // clear ignored while buffers are occupied
        drive(0, 0, 16'd0, 0, 0, 1);
        tick();
        chk("clr_busy_err", {31'd0, err}, 32'd1);
        chk("clr_busy_num", num, 32'd4);
        chk("clr_busy_dcnt", dcnt, 32'd5);

        // drain pending events and buffers, bounded
        drive(0, 0, 16'd0, 1, 0, 0);
        for (int i = 0; i < 8 && valid; i++) tick();
        chk("drain_num", num, 32'd7);
        chk("drain_valid", {31'd0, valid}, 32'd0);
        drive(0, 0, 16'd0, 0, 1, 0);
        for (int i = 0; i < 8 && occ != 4'd0; i++) tick();
        chk("drain_occ", {28'd0, occ}, 32'd0);
        drive(0, 0, 16'd0, 0, 0, 1);
        tick();
        chk("clr_num", num, 32'd0);
        chk("clr_dcnt", dcnt, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_rej", {16'd0, rej}, 32'd0);

        // asynchronous reset in the middle of a holdoff with a buffer in use
        drive(1, 0, 16'd0, 0, 0, 0);
        tick();
        drive(1, 1, 16'd7, 0, 0, 0);
        tick();
        chk("ar_hold_pre", {31'd0, holdoff}, 32'd1);
        chk("ar_occ_pre", {28'd0, occ}, 32'd1);
        trig = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_hold", {31'd0, holdoff}, 32'd0);
        chk("ar_dead", {31'd0, dead}, 32'd1);
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_occ", {28'd0, occ}, 32'd0);
        chk("ar_dcnt", dcnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
